led_fade_driver: RTL and testbench
==================================

# led_fade_driver

Per-LED fade and PWM driver between the LED output PIO and the board LED pins. Takes the PIO's 8-bit on/off word as targets and ramps each LED's brightness toward its target at a programmed rate. Brightness is rendered as a PWM duty cycle, so LEDs fade in and out instead of snapping. Sits in the same clock domain as the PIO; its outputs go straight to top-level pins.

## Interface
- NUM_LEDS, 8, number of channels; matches PIO width
- PWM_BITS, 8, brightness/PWM resolution; MAXLVL = 2^PWM_BITS−1
- FADE_DIV, 50000, clock cycles per fade tick (1 ms at 50 MHz); legal range ≥1
- STEP, 1, level change per tick; legal range 1..MAXLVL
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- led_in  in  NUM_LEDS  on/off targets from the PIO output port
- led_out  out  NUM_LEDS  PWM-modulated LED drive, registered
- busy  out  1  high while any channel has level ≠ its target extreme

## Operation
- led_in is registered once to give tgt[i]. No synchronizer is used because the source shares clk.
- Prescaler counts 0..FADE_DIV−1 and wraps. tick is high for exactly one cycle when the count equals FADE_DIV−1. With FADE_DIV=1, tick is high every cycle.
- Each channel has a PWM_BITS-wide level and a 2-bit state: OFF, RISING, ON, FALLING.
  - OFF (level=0): enter RISING when tgt=1.
  - RISING: on each tick, level ← min(level+STEP, MAXLVL). Enter ON when level reaches MAXLVL. If tgt drops to 0, enter FALLING, keeping the current level.
  - ON (level=MAXLVL): enter FALLING when tgt=0.
  - FALLING: on each tick, level ← max(level−STEP, 0). Enter OFF when level reaches 0. If tgt rises to 1, enter RISING, keeping the current level.
  - State transitions are evaluated every cycle. Level changes happen only on tick.
- Arithmetic uses a PWM_BITS+1-bit intermediate so it saturates and never wraps.
- PWM counter pwm_cnt counts 0..MAXLVL−1 and wraps, for a period of MAXLVL cycles. It is shared by all channels.
- Next led_out[i] = (duty[i] > pwm_cnt). duty = level, or the gamma value when gamma is enabled (see Configuration).
  - level 0 gives a constant 0.
  - level MAXLVL gives a constant 1.
- busy = OR over channels of (state ∈ {RISING, FALLING}).

## Timing
- Reset values:
  - level = 0, state = OFF
  - prescaler = 0, pwm_cnt = 0
  - tgt = 0, led_out = 0, busy = 0
- Reset applied mid-fade returns all of the above on the next edge. There is no residual ramp.
- led_in change → state change: 2 cycles (input register, then state register). busy rises in the same cycle as the state change.
- Level update occurs on the clock edge at which tick=1.
- led_out lags the pwm_cnt/duty compare by 1 cycle.
- A tgt toggle within a single tick period reverses direction at the next tick without skipping a step.
- A tick that coincides with a state change applies the step in the new direction.

## Configuration
- LED_FADE_GAMMA_EN:
  - Defined: duty = (level·level) >> PWM_BITS, except duty = MAXLVL when level = MAXLVL. This gives perceptual fade. The multiply is combinational, one per channel.
  - Undefined: duty = level (linear).
- State machine, busy, and timing are identical in both builds.

## Structure
- Package led_fade_pkg holds:
  - the state enum: OFF, RISING, ON, FALLING
  - the default constants for PWM_BITS and MAXLVL
- Sub-module led_fade_channel: one instance per LED, generated NUM_LEDS times.
  - Contains the state, level, and duty logic plus the output compare register.
  - Top level holds the input register, prescaler, PWM counter, and busy OR.

## Test plan
Bench parameters: FADE_DIV=4, STEP=64, PWM_BITS=8.

- Reset and idle: reset high 3 cycles, led_in=0x00 → led_out=0x00, busy=0, all levels 0 for 1000 cycles.
- Ramp up: led_in=0x01 → level[0] goes 64, 128, 192, 255 on successive ticks (4 cycles apart). busy falls when 255 is reached. led_out[0] is then constantly 1.
- Reversal mid-ramp: led_in=0x01 until level[0]=128, then 0x00 → next ticks give 64, then 0. State ends OFF and busy=0.
- PWM duty: hold level[3]=128 (linear build) → led_out[3] is high 128 of every 255 cycles. Gamma build → high 64 of every 255.
- Reset mid-fade: reset asserted while level[5]=192 and FALLING → next cycle level=0, led_out=0x00, busy=0.
- All channels: led_in=0xFF then 0xA5 once all reach ON → bits 1, 3, 4, 6 fall to 0, the others stay at 255. busy is high only during that fall.

Source files
------------

// File: rtl/led_fade_pkg.sv
// Shared types and default constants for the LED fade/PWM driver.
package led_fade_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        RISING  = 2'd1,
        ON      = 2'd2,
        FALLING = 2'd3
    } fade_state_t;

    localparam int DEF_PWM_BITS = 8;
    localparam int DEF_MAXLVL   = (1 << DEF_PWM_BITS) - 1;

endpackage

// File: rtl/led_fade_driver_if.sv
// LED target/drive bundle between the PIO side (master) and the fade driver (slave).
interface led_fade_if #(
    parameter int NUM_LEDS = 8
);
    logic [NUM_LEDS-1:0] led_in;
    logic [NUM_LEDS-1:0] led_out;
    logic                busy;

    modport master (output led_in, input led_out, input busy);
    modport slave  (input led_in, output led_out, output busy);
endinterface

// File: rtl/led_fade_driver_channel.sv
// One LED channel: fade state machine, saturating level ramp, duty mapping and PWM compare.
// Define LED_FADE_GAMMA_EN for a squared (perceptual) duty curve; linear otherwise.
module led_fade_channel
    import led_fade_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int STEP     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tgt,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                active
);

    localparam logic [PWM_BITS-1:0] MAXLVL   = '1;
    localparam logic [PWM_BITS:0]   STEP_EXT = (PWM_BITS+1)'(STEP);

    fade_state_t         state;
    fade_state_t         state_next;
    fade_state_t         dir;
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] level_next;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS:0]   up_sum;
    logic [PWM_BITS:0]   down_diff;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= OFF;
            level <= '0;
            led   <= 1'b0;
        end else begin
            state <= state_next;
            level <= level_next;
            led   <= (duty > pwm_cnt);
        end
    end

    // Direction follows the target first, so a coinciding tick steps the new way.
    always_comb begin
        dir = state;
        case (state)
            OFF:     if (tgt)  dir = RISING;
            RISING:  if (!tgt) dir = FALLING;
            ON:      if (!tgt) dir = FALLING;
            FALLING: if (tgt)  dir = RISING;
            default: dir = OFF;
        endcase

        up_sum    = {1'b0, level} + STEP_EXT;
        down_diff = {1'b0, level} - STEP_EXT;

        level_next = level;
        if (tick && dir == RISING) begin
            level_next = up_sum[PWM_BITS] ? MAXLVL : up_sum[PWM_BITS-1:0];
        end else if (tick && dir == FALLING) begin
            level_next = down_diff[PWM_BITS] ? '0 : down_diff[PWM_BITS-1:0];
        end

        state_next = dir;
        if (dir == RISING && level_next == MAXLVL) begin
            state_next = ON;
        end else if (dir == FALLING && level_next == '0) begin
            state_next = OFF;
        end
    end

    assign active = (state == RISING) || (state == FALLING);

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] square;

    // Full scale is forced so a lit LED stays solidly on rather than 254/255.
    always_comb begin
        square = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level};
        duty   = (level == MAXLVL) ? MAXLVL : square[2*PWM_BITS-1:PWM_BITS];
    end
`else
    assign duty = level;
`endif

endmodule

// File: rtl/led_fade_driver.sv
// Per-LED fade and PWM driver: input register, fade prescaler, shared PWM counter, busy OR.
// Define LED_FADE_GAMMA_EN to enable the gamma duty curve in every channel.
module led_fade_driver
    import led_fade_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int FADE_DIV = 50000,
    parameter int STEP     = 1
) (
    input  logic       clk,
    input  logic       reset,
    led_fade_if.slave  bus
);

    localparam int                  PRESC_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(FADE_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST   = {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic [NUM_LEDS-1:0] tgt;
    logic [NUM_LEDS-1:0] ch_led;
    logic [NUM_LEDS-1:0] ch_active;
    logic [PRESC_W-1:0]  presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;

    assign tick = (presc == PRESC_LAST);

    // The PIO shares clk, so a single register is enough for led_in.
    always_ff @(posedge clk) begin
        if (reset) begin
            tgt     <= '0;
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            tgt     <= bus.led_in;
            presc   <= tick ? '0 : presc + 1'b1;
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
        led_fade_channel #(
            .PWM_BITS (PWM_BITS),
            .STEP     (STEP)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .tgt     (tgt[gi]),
            .tick    (tick),
            .pwm_cnt (pwm_cnt),
            .led     (ch_led[gi]),
            .active  (ch_active[gi])
        );
    end

    assign bus.led_out = ch_led;
    assign bus.busy    = |ch_active;

endmodule

// File: tb/tb_led_fade_driver.sv
// Self-checking bench for led_fade_driver: cycle scoreboard against a level model, plus a slow-tick duty measurement.
module tb_led_fade_driver;

    localparam int NUM_LEDS  = 8;
    localparam int PWM_BITS  = 8;
    localparam int FADE_DIV  = 4;
    localparam int STEP      = 64;
    localparam int MAXLVL    = 255;
    localparam int HOLD_DIV  = 2000;
    localparam int HOLD_STEP = 128;
`ifdef LED_FADE_GAMMA_EN
    localparam int EXP_HOLD  = 256;
`else
    localparam int EXP_HOLD  = 512;
`endif

    typedef struct packed {
        logic [NUM_LEDS-1:0] led;
        logic                busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset2 = 1'b1;
    always #5 clk = ~clk;

    led_fade_if #(.NUM_LEDS(NUM_LEDS)) bus ();
    led_fade_if #(.NUM_LEDS(NUM_LEDS)) bus2 ();

    led_fade_driver #(
        .NUM_LEDS (NUM_LEDS),
        .PWM_BITS (PWM_BITS),
        .FADE_DIV (FADE_DIV),
        .STEP     (STEP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Slow-tick instance: level sits at 128 for a whole tick period so duty can be measured.
    led_fade_driver #(
        .NUM_LEDS (NUM_LEDS),
        .PWM_BITS (PWM_BITS),
        .FADE_DIV (HOLD_DIV),
        .STEP     (HOLD_STEP)
    ) dut_hold (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2)
    );

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    int m_lvl[NUM_LEDS];
    logic [NUM_LEDS-1:0] m_tgt = '0;
    int m_presc = 0;
    int m_pwm = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int modelDuty(input int lvl);
`ifdef LED_FADE_GAMMA_EN
        return (lvl == MAXLVL) ? MAXLVL : ((lvl * lvl) >> PWM_BITS);
`else
        return lvl;
`endif
    endfunction

    // Advance the reference by one clock edge and queue what the DUT must show after it.
    task automatic modelEdge();
        logic [NUM_LEDS-1:0] nled;
        logic nbusy;
        int nl;
        nled = '0;
        nbusy = 1'b0;
        if (reset) begin
            for (int i = 0; i < NUM_LEDS; i++) m_lvl[i] = 0;
            m_tgt = '0;
            m_presc = 0;
            m_pwm = 0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                nled[i] = (modelDuty(m_lvl[i]) > m_pwm);
                nl = m_lvl[i];
                if (m_presc == FADE_DIV - 1) nl = m_tgt[i] ? nl + STEP : nl - STEP;
                if (nl > MAXLVL) nl = MAXLVL;
                if (nl < 0) nl = 0;
                if (!((nl == 0 && !m_tgt[i]) || (nl == MAXLVL && m_tgt[i]))) nbusy = 1'b1;
                m_lvl[i] = nl;
            end
            m_presc = (m_presc + 1) % FADE_DIV;
            m_pwm = (m_pwm + 1) % MAXLVL;
            m_tgt = bus.led_in;
        end
        sb.push_back('{led: nled, busy: nbusy});
    endtask

    task automatic applyStimulus(input logic rst, input logic [NUM_LEDS-1:0] leds);
        reset = rst;
        bus.led_in = leds;
    endtask

    task automatic stepCycle();
        exp_t e;
        modelEdge();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkOutput("led_out", 32'(bus.led_out), 32'(e.led));
        checkOutput("busy", 32'(bus.busy), 32'(e.busy));
    endtask

    task automatic waitQuiet(input string tag, input int limit);
        int n = 0;
        repeat (3) stepCycle();
        while (bus.busy !== 1'b0 && n < limit) begin
            stepCycle();
            n++;
        end
        checkOutput(tag, 32'(n >= limit), 32'd0);
    endtask

    task automatic waitLevel(input int ch, input int lvl);
        int n = 0;
        while (m_lvl[ch] != lvl && n < 200) begin
            stepCycle();
            n++;
        end
    endtask

    task automatic holdSteady(input string tag, input logic [NUM_LEDS-1:0] want, input int cycles);
        int bad = 0;
        repeat (cycles) begin
            stepCycle();
            if (bus.led_out !== want || bus.busy !== 1'b0) bad++;
        end
        checkOutput(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int highs;
        bus2.led_in = '0;

        applyStimulus(1'b1, 8'h00);
        repeat (3) stepCycle();
        checkOutput("reset_led", 32'(bus.led_out), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        applyStimulus(1'b0, 8'h00);
        holdSteady("idle", 8'h00, 1000);

        applyStimulus(1'b0, 8'h01);
        waitQuiet("ramp_up_timeout", 50);
        holdSteady("ramp_up_on", 8'h01, 300);

        applyStimulus(1'b0, 8'h00);
        waitQuiet("fall_timeout", 50);
        applyStimulus(1'b0, 8'h01);
        waitLevel(0, 128);
        applyStimulus(1'b0, 8'h00);
        waitQuiet("reversal_timeout", 50);
        holdSteady("reversal_off", 8'h00, 300);

        applyStimulus(1'b0, 8'h20);
        waitLevel(5, 192);
        applyStimulus(1'b0, 8'h00);
        stepCycle();
        stepCycle();
        checkOutput("pre_reset_busy", 32'(bus.busy), 32'd1);
        applyStimulus(1'b1, 8'h00);
        stepCycle();
        checkOutput("mid_reset_led", 32'(bus.led_out), 32'd0);
        checkOutput("mid_reset_busy", 32'(bus.busy), 32'd0);
        applyStimulus(1'b0, 8'h00);
        holdSteady("post_reset_idle", 8'h00, 50);

        applyStimulus(1'b0, 8'hFF);
        waitQuiet("all_on_timeout", 50);
        holdSteady("all_on", 8'hFF, 300);
        applyStimulus(1'b0, 8'hA5);
        waitQuiet("a5_timeout", 50);
        holdSteady("a5_steady", 8'hA5, 300);

        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'b0, 8'($urandom));
            repeat ($urandom_range(1, 24)) stepCycle();
        end

        // Slow instance: first tick lands at edge 2000 after reset, next at 4000.
        @(posedge clk);
        #1;
        reset2 = 1'b1;
        bus2.led_in = '0;
        repeat (3) @(posedge clk);
        #1;
        reset2 = 1'b0;
        bus2.led_in = 8'h08;
        repeat (2100) @(posedge clk);
        #1;
        checkOutput("hold_busy", 32'(bus2.busy), 32'd1);
        highs = 0;
        repeat (4 * MAXLVL) begin
            @(posedge clk);
            #1;
            highs += int'(bus2.led_out[3]);
        end
        checkOutput("hold_duty", 32'(highs), 32'(EXP_HOLD));
        checkOutput("hold_others", 32'(bus2.led_out & 8'hF7), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
